// File: rtl/rc5_arbiter.sv
// Round-robin arbiter that shares one RC5 core between two requesters.
// One job is in flight at a time; a watchdog aborts jobs the core never finishes.
module rc5_arbiter #(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_mode,
  input  logic [4:0]  req0_rounds,
  input  logic [31:0] req0_data,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_mode,
  input  logic [4:0]  req1_rounds,
  input  logic [31:0] req1_data,

  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic        resp_err,
  output logic [31:0] resp_data,

  output logic        core_encrypt,
  output logic        core_decrypt,
  output logic [4:0]  core_num_rounds,
  output logic [31:0] core_d_in,
  input  logic [31:0] core_d_out,
  input  logic        core_done,
  output logic        core_rst_n
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [5:0] WDOG_LAST = 6'(TIMEOUT - 1);

  state_t      state_q;
  logic        last_grant_q;
  logic        mode_q;
  logic        id_q;
  logic [4:0]  rounds_q;
  logic [31:0] data_q;
  logic [5:0]  wdog_q;
  logic        resp_valid_q;
  logic        resp_id_q;
  logic        resp_err_q;
  logic [31:0] resp_data_q;
  logic        core_rst_n_q;

  logic        grant;
  logic        accept;
  logic        id_d;
  logic        mode_d;
  logic [4:0]  rounds_raw;
  logic [4:0]  rounds_d;
  logic [31:0] data_d;

  // With both requesting, the side not served last wins.
  always_comb begin
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else begin
      grant = req1_valid;
    end
  end

  assign req0_ready = ~rst & (state_q == IDLE) & req0_valid & ~grant;
  assign req1_ready = ~rst & (state_q == IDLE) & req1_valid &  grant;
  assign accept     = req0_ready | req1_ready;

  assign id_d       = grant;
  assign mode_d     = grant ? req1_mode   : req0_mode;
  assign rounds_raw = grant ? req1_rounds : req0_rounds;
  assign data_d     = grant ? req1_data   : req0_data;
  assign rounds_d   = (rounds_raw > 5'd16) ? 5'd16 : rounds_raw;

  assign core_encrypt    = ~rst & (state_q == LAUNCH) & ~mode_q;
  assign core_decrypt    = ~rst & (state_q == LAUNCH) &  mode_q;
  assign core_num_rounds = rounds_q;
  assign core_d_in       = data_q;
  assign core_rst_n      = ~rst & core_rst_n_q;

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_err   = resp_err_q;
  assign resp_data  = resp_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      mode_q       <= 1'b0;
      id_q         <= 1'b0;
      rounds_q     <= 5'd0;
      data_q       <= 32'd0;
      wdog_q       <= 6'd0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= 32'd0;
      core_rst_n_q <= 1'b1;
    end else begin
      core_rst_n_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            mode_q       <= mode_d;
            id_q         <= id_d;
            rounds_q     <= rounds_d;
            data_q       <= data_d;
            last_grant_q <= id_d;
            state_q      <= LAUNCH;
          end
        end
        LAUNCH: begin
          wdog_q  <= 6'd0;
          state_q <= WAIT;
        end
        WAIT: begin
          wdog_q <= wdog_q + 6'd1;
          // A done arriving on the timeout cycle still counts as success.
          if (core_done) begin
            resp_data_q  <= core_d_out;
            resp_err_q   <= 1'b0;
            resp_id_q    <= id_q;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else if (wdog_q == WDOG_LAST) begin
            resp_data_q  <= 32'd0;
            resp_err_q   <= 1'b1;
            resp_id_q    <= id_q;
            resp_valid_q <= 1'b1;
            core_rst_n_q <= 1'b0;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc5_arbiter.sv
// Bench for rc5_arbiter: directed scenarios plus randomized jobs against a
// cycle-count reference model and a behavioural RC5 core stand-in.
module tb_rc5_arbiter;
  localparam int TIMEOUT = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_mode, req0_ready;
  logic        req1_valid, req1_mode, req1_ready;
  logic [4:0]  req0_rounds, req1_rounds;
  logic [31:0] req0_data, req1_data;
  logic        resp_valid, resp_ready, resp_id, resp_err;
  logic [31:0] resp_data;
  logic        core_encrypt, core_decrypt, core_done, core_rst_n;
  logic [4:0]  core_num_rounds;
  logic [31:0] core_d_in, core_d_out;

  int checks = 0;
  int errors = 0;
  logic last_g;

  logic        core_hang   = 1'b0;
  int          force_delay = 0;
  logic        use_fixed   = 1'b0;
  logic [31:0] fixed_val   = 32'd0;
  logic        extra_done  = 1'b0;

  rc5_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode),
    .req0_rounds(req0_rounds), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode),
    .req1_rounds(req1_rounds), .req1_data(req1_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_err(resp_err), .resp_data(resp_data),
    .core_encrypt(core_encrypt), .core_decrypt(core_decrypt),
    .core_num_rounds(core_num_rounds), .core_d_in(core_d_in),
    .core_d_out(core_d_out), .core_done(core_done), .core_rst_n(core_rst_n)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] core_fn(input logic [31:0] d, input logic enc);
    return enc ? ((d ^ 32'h5A5A_A5A5) + 32'h0000_1111) : ({d[15:0], d[31:16]} ^ 32'h0F0F_0F0F);
  endfunction

  // Cycles from the LAUNCH cycle (1) to the first cycle showing resp_valid.
  function automatic int exp_latency(input logic [4:0] r);
    int re;
    re = (r > 5'd16) ? 16 : int'(r);
    return (re == 0) ? 3 : re + 4;
  endfunction

  // Core stand-in: done lands exactly where the core timing contract puts it.
  initial begin
    int cnt;
    logic [31:0] res;
    cnt = 0;
    res = 32'd0;
    core_done = 1'b0;
    core_d_out = 32'd0;
    forever begin
      @(negedge clk);
      #2;
      core_done = 1'b0;
      if (core_rst_n !== 1'b1) cnt = 0;
      if (extra_done) begin
        core_done  = 1'b1;
        core_d_out = 32'hDEAD_BEEF;
        extra_done = 1'b0;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          core_done  = 1'b1;
          core_d_out = res;
        end
      end
      if ((core_encrypt === 1'b1 || core_decrypt === 1'b1) && !core_hang) begin
        cnt = (force_delay != 0) ? force_delay :
              ((core_num_rounds == 5'd0) ? 1 : 2 + int'(core_num_rounds));
        res = use_fixed ? fixed_val : core_fn(core_d_in, core_encrypt);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "bench time limit reached");
  end

  task automatic drive(input logic v0, input logic m0, input logic [4:0] r0, input logic [31:0] d0,
                       input logic v1, input logic m1, input logic [4:0] r1, input logic [31:0] d1);
    req0_valid = v0; req0_mode = m0; req0_rounds = r0; req0_data = d0;
    req1_valid = v1; req1_mode = m1; req1_rounds = r1; req1_data = d1;
    #1;
  endtask

  // Called just after the handshake edge; measures the job without judging it.
  task automatic observe(output int k_resp, output int n_enc, output int n_dec, output int n_rstn,
                         output int pulse_k, output logic [4:0] nr, output logic [31:0] din,
                         output logic stable);
    int k;
    k = 0; k_resp = -1; n_enc = 0; n_dec = 0; n_rstn = 0; pulse_k = -1;
    nr = 5'd0; din = 32'd0; stable = 1'b1;
    while (k < 200) begin
      @(negedge clk);
      k++;
      if (core_encrypt === 1'b1) n_enc++;
      if (core_decrypt === 1'b1) n_dec++;
      if ((core_encrypt === 1'b1 || core_decrypt === 1'b1) && pulse_k < 0) pulse_k = k;
      if (core_rst_n !== 1'b1) n_rstn++;
      if (k == 1) begin
        nr = core_num_rounds;
        din = core_d_in;
      end else if (resp_valid !== 1'b1 && (core_num_rounds !== nr || core_d_in !== din)) begin
        stable = 1'b0;
      end
      if (resp_valid === 1'b1) begin
        k_resp = k;
        break;
      end
    end
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    resp_ready = 1'b0;
    drive(1'b1, 1'b0, 5'd3, 32'h1, 1'b1, 1'b1, 5'd4, 32'h2);
    repeat (2) begin
      @(negedge clk); #1;
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++; $display("FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready);
      end
      checks++;
      if (core_encrypt !== 1'b0 || core_decrypt !== 1'b0 || core_rst_n !== 1'b0) begin
        errors++; $display("FAIL reset_core_ctrl: enc=%b dec=%b rst_n=%b expected 0 0 0",
                           core_encrypt, core_decrypt, core_rst_n);
      end
    end
    checks++;
    if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_id !== 1'b0 || resp_data !== 32'd0) begin
      errors++; $display("FAIL reset_resp: valid=%b err=%b id=%b data=%h expected all zero",
                         resp_valid, resp_err, resp_id, resp_data);
    end
    checks++;
    if (core_num_rounds !== 5'd0 || core_d_in !== 32'd0) begin
      errors++; $display("FAIL reset_captured: rounds=%0d d_in=%h expected 0", core_num_rounds, core_d_in);
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    checks++;
    if (core_rst_n !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL reset_release: rst_n=%b ready=%b%b expected 1 00",
                         core_rst_n, req0_ready, req1_ready);
    end
    last_g = 1'b1;
  endtask

  task automatic test_contention();
    int k, ne, nd, nl, pk;
    logic [4:0] nr;
    logic [31:0] din, exp_d;
    logic st, exp_g;
    @(negedge clk);
    drive(1'b1, 1'b0, 5'd3, 32'h1111_2222, 1'b1, 1'b1, 5'd5, 32'h3333_4444);
    for (int j = 0; j < 4; j++) begin
      exp_g = ~last_g;
      checks++;
      if (req0_ready !== !exp_g || req1_ready !== exp_g) begin
        errors++; $display("FAIL contention_grant job %0d: ready=%b%b expected grant %0d",
                           j, req0_ready, req1_ready, exp_g);
      end
      @(posedge clk); #1;
      last_g = exp_g;
      observe(k, ne, nd, nl, pk, nr, din, st);
      exp_d = exp_g ? core_fn(32'h3333_4444, 1'b0) : core_fn(32'h1111_2222, 1'b1);
      checks++;
      if (k !== exp_latency(exp_g ? 5'd5 : 5'd3) || resp_id !== exp_g || resp_err !== 1'b0 ||
          resp_data !== exp_d) begin
        errors++; $display("FAIL contention_resp job %0d: lat=%0d id=%b err=%b data=%h expected lat=%0d id=%b err=0 data=%h",
                           j, k, resp_id, resp_err, resp_data, exp_latency(exp_g ? 5'd5 : 5'd3), exp_g, exp_d);
      end
      resp_ready = 1'b1; #1;
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++; $display("FAIL contention_resp_cycle_accept job %0d: ready=%b%b expected 00",
                           j, req0_ready, req1_ready);
      end
      @(posedge clk); #1;
      resp_ready = 1'b0;
      @(negedge clk); #1;
    end
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_basic_encrypt();
    int k, ne, nd, nl, pk;
    logic [4:0] nr;
    logic [31:0] din;
    logic st;
    @(negedge clk);
    use_fixed = 1'b1;
    fixed_val = 32'hCAFE_F00D;
    drive(1'b1, 1'b0, 5'd12, 32'h1234_5678, 1'b0, 1'b0, 5'd0, 32'd0);
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL basic_ready: ready=%b%b expected 10", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    last_g = 1'b0;
    observe(k, ne, nd, nl, pk, nr, din, st);
    checks++;
    if (pk !== 1 || ne !== 1 || nd !== 0) begin
      errors++; $display("FAIL basic_launch_pulse: at=%0d enc=%0d dec=%0d expected at=1 enc=1 dec=0", pk, ne, nd);
    end
    checks++;
    if (k !== 16) begin
      errors++; $display("FAIL basic_latency: got %0d expected 16", k);
    end
    checks++;
    if (resp_id !== 1'b0 || resp_err !== 1'b0 || resp_data !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL basic_resp: id=%b err=%b data=%h expected 0 0 cafef00d", resp_id, resp_err, resp_data);
    end
    checks++;
    if (nr !== 5'd12 || din !== 32'h1234_5678 || st !== 1'b1) begin
      errors++; $display("FAIL basic_core_inputs: rounds=%0d d_in=%h stable=%b expected 12 12345678 1", nr, din, st);
    end
    finish_resp();
    use_fixed = 1'b0;
  endtask

  task automatic test_clamp_zero();
    int k, ne, nd, nl, pk;
    logic [4:0] nr;
    logic [31:0] din;
    logic st;
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd31, 32'h7777_0001);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    last_g = 1'b1;
    observe(k, ne, nd, nl, pk, nr, din, st);
    checks++;
    if (nr !== 5'd16 || k !== 20 || resp_data !== core_fn(32'h7777_0001, 1'b1)) begin
      errors++; $display("FAIL clamp_31: rounds=%0d lat=%0d data=%h expected 16 20 %h",
                         nr, k, resp_data, core_fn(32'h7777_0001, 1'b1));
    end
    finish_resp();
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd0, 32'h0000_BEEF);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    observe(k, ne, nd, nl, pk, nr, din, st);
    checks++;
    if (nd !== 1 || ne !== 0 || pk !== 1 || nr !== 5'd0) begin
      errors++; $display("FAIL zero_rounds_pulse: dec=%0d enc=%0d at=%0d rounds=%0d expected 1 0 1 0", nd, ne, pk, nr);
    end
    checks++;
    if (k !== 3 || resp_data !== core_fn(32'h0000_BEEF, 1'b0) || resp_err !== 1'b0) begin
      errors++; $display("FAIL zero_rounds_resp: lat=%0d data=%h err=%b expected 3 %h 0",
                         k, resp_data, resp_err, core_fn(32'h0000_BEEF, 1'b0));
    end
    finish_resp();
  endtask

  task automatic test_timeout();
    int k, ne, nd, nl, pk;
    logic [4:0] nr;
    logic [31:0] din;
    logic st;
    core_hang = 1'b1;
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd5, 32'h2468_ACE0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    last_g = 1'b1;
    observe(k, ne, nd, nl, pk, nr, din, st);
    checks++;
    if (k !== TIMEOUT + 2 || resp_err !== 1'b1 || resp_data !== 32'd0 || resp_id !== 1'b1) begin
      errors++; $display("FAIL timeout_resp: lat=%0d err=%b data=%h id=%b expected %0d 1 0 1",
                         k, resp_err, resp_data, resp_id, TIMEOUT + 2);
    end
    checks++;
    if (nl !== 1 || core_rst_n !== 1'b0) begin
      errors++; $display("FAIL timeout_core_rst: low_cycles=%0d rst_n_now=%b expected 1 0", nl, core_rst_n);
    end
    @(negedge clk); #1;
    checks++;
    if (core_rst_n !== 1'b1 || resp_valid !== 1'b1) begin
      errors++; $display("FAIL timeout_rst_release: rst_n=%b valid=%b expected 1 1", core_rst_n, resp_valid);
    end
    finish_resp();
    core_hang = 1'b0;
  endtask

  task automatic test_done_at_timeout();
    int k, ne, nd, nl, pk;
    logic [4:0] nr;
    logic [31:0] din;
    logic st;
    force_delay = TIMEOUT;
    @(negedge clk);
    drive(1'b1, 1'b0, 5'd8, 32'h1357_9BDF, 1'b0, 1'b0, 5'd0, 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    last_g = 1'b0;
    observe(k, ne, nd, nl, pk, nr, din, st);
    checks++;
    if (k !== TIMEOUT + 2 || resp_err !== 1'b0 || resp_data !== core_fn(32'h1357_9BDF, 1'b1) || nl !== 0) begin
      errors++; $display("FAIL done_beats_timeout: lat=%0d err=%b data=%h rst_low=%0d expected %0d 0 %h 0",
                         k, resp_err, resp_data, nl, TIMEOUT + 2, core_fn(32'h1357_9BDF, 1'b1));
    end
    finish_resp();
    force_delay = TIMEOUT + 1;
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd8, 32'h1357_9BDF, 1'b0, 1'b0, 5'd0, 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    observe(k, ne, nd, nl, pk, nr, din, st);
    checks++;
    if (k !== TIMEOUT + 2 || resp_err !== 1'b1 || resp_data !== 32'd0) begin
      errors++; $display("FAIL done_one_late: lat=%0d err=%b data=%h expected %0d 1 0",
                         k, resp_err, resp_data, TIMEOUT + 2);
    end
    finish_resp();
    force_delay = 0;
  endtask

  task automatic test_backpressure();
    int k, ne, nd, nl, pk;
    logic [4:0] nr;
    logic [31:0] din, exp_d;
    logic st;
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd2, 32'h0F1E_2D3C, 1'b0, 1'b0, 5'd0, 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    last_g = 1'b0;
    observe(k, ne, nd, nl, pk, nr, din, st);
    exp_d = core_fn(32'h0F1E_2D3C, 1'b0);
    checks++;
    if (k !== 6 || resp_data !== exp_d) begin
      errors++; $display("FAIL backpressure_first: lat=%0d data=%h expected 6 %h", k, resp_data, exp_d);
    end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) extra_done = 1'b1;
      if (i == 7) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      @(negedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== exp_d || resp_id !== 1'b0 || resp_err !== 1'b0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++; $display("FAIL backpressure_hold cyc %0d: valid=%b data=%h id=%b err=%b ready=%b%b expected 1 %h 0 0 00",
                           i, resp_valid, resp_data, resp_id, resp_err, req0_ready, req1_ready, exp_d);
      end
    end
    finish_resp();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++;
      if (core_encrypt !== 1'b0 || core_decrypt !== 1'b0 || resp_valid !== 1'b0) begin
        errors++; $display("FAIL dropped_valid_no_launch cyc %0d: enc=%b dec=%b valid=%b expected 0 0 0",
                           i, core_encrypt, core_decrypt, resp_valid);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    int k, ne, nd, nl, pk;
    logic [4:0] nr;
    logic [31:0] din;
    logic st;
    @(negedge clk);
    drive(1'b1, 1'b0, 5'd16, 32'hA5A5_0001, 1'b0, 1'b0, 5'd0, 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd4, 32'h0BAD_F00D);
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || core_encrypt !== 1'b0 || core_decrypt !== 1'b0 ||
        core_rst_n !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs: ready=%b%b enc=%b dec=%b rst_n=%b expected 00 0 0 0",
                         req0_ready, req1_ready, core_encrypt, core_decrypt, core_rst_n);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    last_g = 1'b1;
    checks++;
    if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_data !== 32'd0 || req1_ready !== 1'b1 ||
        req0_ready !== 1'b0) begin
      errors++; $display("FAIL midreset_after: valid=%b err=%b data=%h ready=%b%b expected 0 0 0 01",
                         resp_valid, resp_err, resp_data, req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    observe(k, ne, nd, nl, pk, nr, din, st);
    checks++;
    if (k !== exp_latency(5'd4) || resp_id !== 1'b1 || resp_err !== 1'b0 ||
        resp_data !== core_fn(32'h0BAD_F00D, 1'b0)) begin
      errors++; $display("FAIL midreset_next_job: lat=%0d id=%b err=%b data=%h expected %0d 1 0 %h",
                         k, resp_id, resp_err, resp_data, exp_latency(5'd4), core_fn(32'h0BAD_F00D, 1'b0));
    end
    finish_resp();
  endtask

  task automatic test_random(input int n);
    int k, ne, nd, nl, pk, pick;
    logic [4:0] nr, r0, r1, r_sel, r_eff;
    logic [31:0] din, d0, d1, d_sel, exp_d;
    logic st, v0, v1, m0, m1, m_sel, g;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      pick = int'($urandom_range(1, 3));
      v0 = (pick != 2);
      v1 = (pick != 1);
      m0 = 1'($urandom_range(0, 1));
      m1 = 1'($urandom_range(0, 1));
      r0 = 5'($urandom_range(0, 31));
      r1 = 5'($urandom_range(0, 31));
      d0 = $urandom;
      d1 = $urandom;
      drive(v0, m0, r0, d0, v1, m1, r1, d1);
      g = (v0 && v1) ? ~last_g : v1;
      checks++;
      if (req0_ready !== (v0 & ~g) || req1_ready !== (v1 & g)) begin
        errors++; $display("FAIL rand_grant job %0d: ready=%b%b expected %b%b",
                           j, req0_ready, req1_ready, v0 & ~g, v1 & g);
      end
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
      last_g = g;
      m_sel = g ? m1 : m0;
      r_sel = g ? r1 : r0;
      d_sel = g ? d1 : d0;
      r_eff = (r_sel > 5'd16) ? 5'd16 : r_sel;
      exp_d = core_fn(d_sel, ~m_sel);
      observe(k, ne, nd, nl, pk, nr, din, st);
      checks++;
      if (k !== exp_latency(r_sel)) begin
        errors++; $display("FAIL rand_latency job %0d: got %0d expected %0d (rounds %0d)", j, k, exp_latency(r_sel), r_sel);
      end
      checks++;
      if (resp_id !== g || resp_err !== 1'b0 || resp_data !== exp_d) begin
        errors++; $display("FAIL rand_resp job %0d: id=%b err=%b data=%h expected %b 0 %h",
                           j, resp_id, resp_err, resp_data, g, exp_d);
      end
      checks++;
      if (ne !== (m_sel ? 0 : 1) || nd !== (m_sel ? 1 : 0) || pk !== 1) begin
        errors++; $display("FAIL rand_pulse job %0d: enc=%0d dec=%0d at=%0d expected mode %b one pulse at 1",
                           j, ne, nd, pk, m_sel);
      end
      checks++;
      if (nr !== r_eff || din !== d_sel || st !== 1'b1) begin
        errors++; $display("FAIL rand_core_inputs job %0d: rounds=%0d d_in=%h stable=%b expected %0d %h 1",
                           j, nr, din, st, r_eff, d_sel);
      end
      finish_resp();
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_basic_encrypt();
    test_clamp_zero();
    test_timeout();
    test_done_at_timeout();
    test_backpressure();
    test_reset_mid_wait();
    test_random(40);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
